// File: rtl/data_sram_resp_if.sv
// Request/response bus between the EXE/MEM stages and the data SRAM responder.
interface data_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_resp.sv
// Single-port, zero-wait-state data SRAM with per-byte writes, access counters and range flag.
// Optional per-byte parity checking is enabled by defining DSRAM_PARITY_EN.
module data_sram_resp #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  data_sram_resp_if.slave   bus,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt,
  output logic              addr_err
`ifdef DSRAM_PARITY_EN
  ,
  input  logic              par_inj,
  output logic              par_err
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              wr_req;
  logic              rd_req;

  assign idx      = bus.data_sram_addr[ADDR_W+1:2];
  assign in_range = (bus.data_sram_addr >> (ADDR_W + 2)) == 32'd0;
  assign wr_req   = !reset && bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
  assign rd_req   = !reset && bus.data_sram_en && (bus.data_sram_wen == 4'b0000);

  // The array itself is never reset; contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (wr_req && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_wen[i])
          mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data_sram_rdata <= 32'h0;
      rd_cnt              <= 32'h0;
      wr_cnt              <= 32'h0;
      addr_err            <= 1'b0;
    end else if (bus.data_sram_en) begin
      if (!in_range)
        addr_err <= 1'b1;
      if (bus.data_sram_wen == 4'b0000) begin
        bus.data_sram_rdata <= in_range ? mem[idx] : 32'h0;
        if (rd_cnt != 32'hFFFF_FFFF)
          rd_cnt <= rd_cnt + 32'd1;
      end else if (wr_cnt != 32'hFFFF_FFFF) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
    end
  end

`ifdef DSRAM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] vld_mem [DEPTH];
  logic [3:0] rd_par;

  always_comb begin
    rd_par = 4'b0000;
    for (int i = 0; i < 4; i++)
      rd_par[i] = ^mem[idx][8*i +: 8];
  end

  // Injection inverts the stored parity so a later read of that lane mismatches.
  always_ff @(posedge clk) begin
    if (wr_req && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_wen[i])
          par_mem[idx][i] <= (^bus.data_sram_wdata[8*i +: 8]) ^ par_inj;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++)
        vld_mem[j] <= 4'b0000;
      par_err <= 1'b0;
    end else begin
      if (wr_req && in_range)
        vld_mem[idx] <= vld_mem[idx] | bus.data_sram_wen;
      if (rd_req && in_range && ((vld_mem[idx] & (rd_par ^ par_mem[idx])) != 4'b0000))
        par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Data-side SRAM responder for the five-stage MIPS pipeline. It serves the `data_sram_*` interface: the EXE stage drives each request, and the MEM stage samples `data_sram_rdata` one cycle later, with no wait states. The block holds the word-organised data memory, applies per-byte write enables for `sb`/`sh`/`sw`/`swl`/`swr`, and returns whole aligned words; load extraction stays in MEM. It also keeps access counters and flags out-of-range accesses for the debug bench.

## Interface
- `ADDR_W`, default 10: word-index width; the memory holds 2^ADDR_W 32-bit words.
- `clk` in, 1: clock.
- `reset` in, 1: synchronous, active-high; clock is `clk`.
- `data_sram_en` in, 1: request valid this cycle.
- `data_sram_wen` in, 4: byte write enables; bit i writes byte lane i (bits 8i+7:8i). 0000 means read.
- `data_sram_addr` in, 32: byte address; bits 1:0 ignored.
- `data_sram_wdata` in, 32: write data, already lane-aligned by EXE.
- `data_sram_rdata` out, 32: registered read data.
- `rd_cnt` out, 32: number of accepted reads.
- `wr_cnt` out, 32: number of accepted writes.
- `addr_err` out, 1: sticky out-of-range flag.
- `par_inj` in, 1: present only with `DSRAM_PARITY_EN`; test-only parity corruption.
- `par_err` out, 1: present only with `DSRAM_PARITY_EN`; sticky parity-error flag.

## Operation
- Word index `idx = data_sram_addr[ADDR_W+1:2]`.
- In range: `data_sram_addr[31:ADDR_W+2] == 0`.
- Each cycle with `en=1` is exactly one access. There is one port, so read and write never happen together.
- Write (`en=1`, `wen!=0`, in range):
  - Each lane with `wen[i]=1` takes `wdata` lane i; other lanes keep their value.
  - `wr_cnt` increments.
  - `data_sram_rdata` is unchanged (no-change mode).
- Read (`en=1`, `wen=0`, in range):
  - `data_sram_rdata <= mem[idx]` at the clock edge.
  - `rd_cnt` increments.
- Out of range with `en=1`:
  - Writes are dropped.
  - Reads load `data_sram_rdata <= 32'h0`.
  - `addr_err <= 1`; it stays set until reset.
  - The counter still increments, so counters count accepted requests whatever their range.
- `en=0`: no state change; `data_sram_rdata` holds its last value.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- Memory contents are not reset; reading a never-written word returns whatever is there (X in simulation).

## Timing
- Read latency is 1 cycle: a request at edge N gives valid `rdata` after edge N+1. This matches MEM sampling with `ms_ready_go=1`.
- Back-to-back reads are allowed every cycle.
- Write-then-read of the same word on consecutive cycles returns the merged new data. The array is updated at the write edge, so no bypass is needed.
- There is no backpressure: every `en=1` cycle is accepted.
- Reset takes priority over any concurrent request; the request is discarded.
- Reset values:
  - `data_sram_rdata = 0`
  - `rd_cnt = 0`, `wr_cnt = 0`
  - `addr_err = 0`
  - `par_err = 0`
  - all byte-valid bits 0
- Reset in the middle of a pipeline: a read issued the cycle before reset still has its `rdata` overwritten to 0 by the reset edge.

## Configuration
- `DSRAM_PARITY_EN` defined:
  - One even-parity bit and one valid bit are stored per byte; the valid bits are cleared by reset.
  - A write stores parity for each enabled lane and sets that lane's valid bit.
  - If `par_inj=1` during a write, the stored parity of every written lane is inverted.
  - On an in-range read, any lane with valid=1 and a parity mismatch sets sticky `par_err`. Lanes with valid=0 are not checked.
  - Read data is returned unmodified in all cases.
- `DSRAM_PARITY_EN` not defined:
  - There is no parity or valid storage.
  - `par_inj` and `par_err` are not present.
  - All other behaviour is identical.

## Test plan
- Full-word write and read back:
  - Stimulus: write `wen=1111`, addr 0x0000_0010, data 0x1234_5678; next cycle read 0x10.
  - Required: `rdata=0x12345678` one cycle later; `wr_cnt=1`, `rd_cnt=1`.
- Byte-lane merge:
  - Stimulus: after the above, write `wen=0010`, data 0x0000_AB00 to 0x11; then read 0x10.
  - Required: `rdata=0x1234AB78`.
- Hold and no-change mode:
  - Stimulus: read 0x10, then `en=0` for 3 cycles, then a write to 0x20.
  - Required: `rdata` stays 0x1234AB78 for all of those cycles.
- Out of range (`ADDR_W=10`):
  - Stimulus: write to 0x0000_1000, then read 0x0000_1000.
  - Required: `rdata=0`, `addr_err=1`, word 0 unchanged, `wr_cnt` and `rd_cnt` each incremented.
- Reset mid-stream:
  - Stimulus: read issued and `reset` asserted on the next edge.
  - Required: `rdata=0`, counters 0, `addr_err=0`; a later read of 0x10 still returns 0x1234AB78, since memory is retained.
- Parity (with `DSRAM_PARITY_EN`):
  - Stimulus: write `wen=0001`, `par_inj=1` to 0x40, then read 0x40.
  - Required: `par_err=1`.
  - Stimulus: read a never-written word.
  - Required: `par_err` is not set.
